cipher_stream_tx: RTL and testbench
===================================

CIPHER_STREAM_TX -- requirements
Module: cipher_stream_tx

Interface
REQ-001 Parameter N_BYTES, default 16, number of cipher bytes per block (block = 8*N_BYTES bits).
REQ-002 Parameter TIMEOUT_CYCLES, default 4096, collect-phase watchdog limit in clk cycles.
REQ-003 Port clk, input, 1, rising-edge system clock.
REQ-004 Port reset, input, 1, asynchronous, active-high reset.
REQ-005 Ports ct_ce0/ct_we0, input, 1 each, AES cipher port-0 enable and write strobe.
REQ-006 Ports ct_addr0, input, 7, and ct_d0, input, 1, port-0 bit address and bit data.
REQ-007 Ports ct_ce1/ct_we1/ct_addr1/ct_d1, same widths and meanings for AES cipher port 1.
REQ-008 Port ap_done, input, 1, single-cycle AES completion pulse.
REQ-009 Port tx_data, output, 8, byte to the UART transmitter.
REQ-010 Port tx_valid, output, 1, tx_data is valid; tx_ready, input, 1, transmitter accepts.
REQ-011 Port block_data, output, 128, captured cipher block; block_valid, output, 1, block is complete.
REQ-012 Port busy, output, 1, high in any state other than IDLE.
REQ-013 Ports err_overrun and err_timeout, output, 1 each, sticky error flags.

Function
REQ-014 The FSM SHALL have states IDLE, COLLECT, and SEND.
REQ-015 A bit write SHALL occur when ce&&we on a port; buf[addr] <= d.
REQ-016 Simultaneous writes to the same address SHALL resolve with port 1 winning; different addresses SHALL both write.
REQ-017 IDLE->COLLECT on the first write strobe, and that write SHALL be captured.
REQ-018 An ap_done in IDLE SHALL be ignored.
REQ-019 COLLECT->SEND on ap_done; a write in the same cycle as ap_done SHALL be captured.
REQ-020 block_valid SHALL be high throughout SEND; block_data SHALL equal buf at all times.
REQ-021 tx_valid SHALL assert on the first cycle in SEND, one cycle after ap_done is sampled.
REQ-022 The SEND byte order SHALL be k=0..N_BYTES-1, with tx_data=buf[8k+7:8k].
REQ-023 A byte SHALL be accepted only on tx_valid&&tx_ready; the next byte SHALL be presented in the following cycle, giving back-to-back bytes under constant ready.
REQ-024 tx_data SHALL be held stable while tx_valid&&!tx_ready.
REQ-025 On acceptance of the last byte: SEND->IDLE, buf SHALL be cleared to 0, and tx_valid SHALL drop in the next cycle.
REQ-026 Write strobes during SEND SHALL be ignored (buf unchanged) and SHALL set err_overrun.
REQ-027 Bit addresses >= 8*N_BYTES SHALL be ignored.

Reset
REQ-028 Reset SHALL force the FSM to IDLE, and clear buf, the byte index, the watchdog counter, tx_valid, block_valid, busy, err_overrun, and err_timeout to 0, all asynchronously.
REQ-029 A reset asserted mid-COLLECT or mid-SEND SHALL abort the block; no partial byte SHALL be emitted after release.
REQ-030 The error flags SHALL clear only on reset.

Configuration
REQ-031 With macro CIPHER_COLLECT_WATCHDOG_EN defined, the block SHALL count cycles in COLLECT since the last write, restarting from 0 on each write.
REQ-032 When the count reaches TIMEOUT_CYCLES, err_timeout SHALL be set, buf SHALL be cleared, and the FSM SHALL go COLLECT->IDLE.
REQ-033 With the macro undefined, the block SHALL contain no counter, err_timeout SHALL be tied to 0, and COLLECT SHALL wait indefinitely.

Structure
REQ-034 Shared package aes_uart_pkg SHALL hold the FSM state enum, CIPHER_BITS=128, CIPHER_ADDR_W=7, and BYTE_W=8.
REQ-035 Sub-module cipher_byte_mux SHALL select byte k from the 128-bit buffer; it is combinational and the only sub-module.

Verification
REQ-036 Scenario 1: write all 128 bits via port 0 with d=addr[0], then ap_done, with tx_ready=1. Required: 16 consecutive bytes 0xAA, block_valid high during SEND, then IDLE with buf=0.
REQ-037 Scenario 2: write bit 5 through port 0 (d=0) and port 1 (d=1) in the same cycle. Required: buf[5]=1.
REQ-038 Scenario 3: during SEND, tx_ready=0 for 10 cycles on byte 3. Required: tx_data stable and tx_valid high throughout, and the byte index does not advance.
REQ-039 Scenario 4: a write strobe during SEND. Required: err_overrun=1, the transmitted bytes unchanged, and err_overrun remains set until reset.
REQ-040 Scenario 5: reset asserted on byte 7 of SEND. Required: tx_valid=0 and busy=0 immediately; no further bytes after release.
REQ-041 Scenario 6 (CIPHER_COLLECT_WATCHDOG_EN defined, TIMEOUT_CYCLES=16): one write, then silence. Required: err_timeout=1 exactly 16 cycles after the write, FSM in IDLE, and no tx_valid.

Source files
------------

// File: rtl/aes_uart_pkg.sv
// Shared types and widths for the AES-to-UART cipher streaming path.
package aes_uart_pkg;

    localparam int unsigned CIPHER_BITS   = 128;
    localparam int unsigned CIPHER_ADDR_W = 7;
    localparam int unsigned BYTE_W        = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_SEND    = 2'd2
    } state_e;

    // Index width for a byte counter over n bytes (at least one bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cipher_byte_mux.sv
// Combinational selector returning byte i_idx of the cipher block buffer.
module cipher_byte_mux
    import aes_uart_pkg::*;
#(
    parameter int unsigned N_BYTES = CIPHER_BITS / BYTE_W,
    parameter int unsigned IDX_W   = 4
) (
    input  logic [BYTE_W*N_BYTES-1:0] i_block,
    input  logic [IDX_W-1:0]          i_idx,
    output logic [BYTE_W-1:0]         o_byte_c
);

    logic [IDX_W+2:0] w_base;

    assign w_base   = {i_idx, 3'b000};
    assign o_byte_c = i_block[w_base +: BYTE_W];

endmodule

// File: rtl/cipher_stream_tx.sv
// Collects AES cipher bits from two write ports, then streams the block out byte by byte.
// Optional collect-phase watchdog is enabled by defining CIPHER_COLLECT_WATCHDOG_EN.
module cipher_stream_tx
    import aes_uart_pkg::*;
#(
    parameter int unsigned N_BYTES        = CIPHER_BITS / BYTE_W,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ct_ce0,
    input  logic                       ct_we0,
    input  logic [CIPHER_ADDR_W-1:0]   ct_addr0,
    input  logic                       ct_d0,
    input  logic                       ct_ce1,
    input  logic                       ct_we1,
    input  logic [CIPHER_ADDR_W-1:0]   ct_addr1,
    input  logic                       ct_d1,
    input  logic                       ap_done,
    output logic [BYTE_W-1:0]          tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic [BYTE_W*N_BYTES-1:0]  block_data,
    output logic                       block_valid,
    output logic                       busy,
    output logic                       err_overrun,
    output logic                       err_timeout
);

    localparam int unsigned BLK_W = BYTE_W * N_BYTES;
    localparam int unsigned IDX_W = idx_width(N_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [BLK_W-1:0]  r_buf;
    logic [IDX_W-1:0]  r_idx;
    logic              r_tx_valid;
    logic              r_block_valid;
    logic              r_busy;
    logic              r_err_overrun;
    logic              w_wr0, w_wr1, w_strobe;
    logic              w_in0, w_in1;
    logic              w_accept, w_clear, w_timeout;
    logic [BYTE_W-1:0] w_tx_byte;

    assign w_wr0    = ct_ce0 && ct_we0;
    assign w_wr1    = ct_ce1 && ct_we1;
    assign w_strobe = w_wr0 || w_wr1;
    assign w_in0    = w_wr0 && (32'(ct_addr0) < BLK_W);
    assign w_in1    = w_wr1 && (32'(ct_addr1) < BLK_W);
    assign w_accept = (r_state == ST_SEND) && r_tx_valid && tx_ready;

    // Next-state and buffer-clear decode.
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_strobe) w_state_nxt = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (ap_done) begin
                    w_state_nxt = ST_SEND;
                end else if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                    w_clear     = 1'b1;
                end
            end
            ST_SEND: begin
                if (w_accept && (r_idx == LAST_IDX)) begin
                    w_state_nxt = ST_IDLE;
                    w_clear     = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_tx_valid    <= 1'b0;
            r_block_valid <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_tx_valid    <= (w_state_nxt == ST_SEND);
            r_block_valid <= (w_state_nxt == ST_SEND);
            r_busy        <= (w_state_nxt != ST_IDLE);
        end
    end

    // Port 1 is applied last so it wins on an address collision; SEND freezes the buffer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf <= '0;
        end else if (w_clear) begin
            r_buf <= '0;
        end else if (r_state != ST_SEND) begin
            if (w_in0) r_buf[ct_addr0] <= ct_d0;
            if (w_in1) r_buf[ct_addr1] <= ct_d1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx         <= '0;
            r_err_overrun <= 1'b0;
        end else begin
            if (w_accept) begin
                r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
            end else if (r_state != ST_SEND) begin
                r_idx <= '0;
            end
            if ((r_state == ST_SEND) && w_strobe) r_err_overrun <= 1'b1;
        end
    end

`ifdef CIPHER_COLLECT_WATCHDOG_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_wd_cnt;
    logic             r_err_timeout;

    // Fires on the TIMEOUT_CYCLES-th write-free COLLECT cycle; ap_done takes priority.
    assign w_timeout = (r_state == ST_COLLECT) && !w_strobe && !ap_done
                       && (r_wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wd_cnt      <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            if ((r_state == ST_COLLECT) && !w_strobe && !w_timeout) begin
                r_wd_cnt <= r_wd_cnt + CNT_W'(1);
            end else begin
                r_wd_cnt <= '0;
            end
            if (w_timeout) r_err_timeout <= 1'b1;
        end
    end

    assign err_timeout = r_err_timeout;
`else
    logic w_unused_timeout_cfg;

    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign w_timeout            = 1'b0;
    assign err_timeout          = 1'b0;
`endif

    cipher_byte_mux #(
        .N_BYTES (N_BYTES),
        .IDX_W   (IDX_W)
    ) u_byte_mux (
        .i_block  (r_buf),
        .i_idx    (r_idx),
        .o_byte_c (w_tx_byte)
    );

    assign tx_data     = w_tx_byte;
    assign tx_valid    = r_tx_valid;
    assign block_data  = r_buf;
    assign block_valid = r_block_valid;
    assign busy        = r_busy;
    assign err_overrun = r_err_overrun;

endmodule

// File: tb/tb_cipher_stream_tx.sv
// Directed self-checking bench for cipher_stream_tx (watchdog scenario follows CIPHER_COLLECT_WATCHDOG_EN).
module tb_cipher_stream_tx;

    logic         clk = 1'b0;
    logic         reset;
    logic         ct_ce0, ct_we0, ct_d0;
    logic         ct_ce1, ct_we1, ct_d1;
    logic [6:0]   ct_addr0, ct_addr1;
    logic         ap_done;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic [127:0] block_data;
    logic         block_valid;
    logic         busy;
    logic         err_overrun;
    logic         err_timeout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cipher_stream_tx #(
        .N_BYTES        (16),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ct_ce0      (ct_ce0),
        .ct_we0      (ct_we0),
        .ct_addr0    (ct_addr0),
        .ct_d0       (ct_d0),
        .ct_ce1      (ct_ce1),
        .ct_we1      (ct_we1),
        .ct_addr1    (ct_addr1),
        .ct_d1       (ct_d1),
        .ap_done     (ap_done),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .block_data  (block_data),
        .block_valid (block_valid),
        .busy        (busy),
        .err_overrun (err_overrun),
        .err_timeout (err_timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ct_ce0 = 1'b0; ct_we0 = 1'b0; ct_addr0 = 7'd0; ct_d0 = 1'b0;
        ct_ce1 = 1'b0; ct_we1 = 1'b0; ct_addr1 = 7'd0; ct_d1 = 1'b0;
        ap_done = 1'b0;
    endtask

    // mode 0: bit = addr[0] (every byte 0xAA); mode 1: byte k holds the value k.
    function automatic logic pat_bit(input int mode, input int addr);
        int k;
        int b;
        k = addr / 8;
        b = addr % 8;
        if (mode == 0) return (addr & 1) != 0;
        return ((k >> b) & 1) != 0;
    endfunction

    task automatic load_block(input int mode);
        for (int a = 0; a < 128; a++) begin
            ct_ce0 = 1'b1; ct_we0 = 1'b1; ct_addr0 = 7'(a); ct_d0 = pat_bit(mode, a);
            tick();
        end
        idle_inputs();
    endtask

    task automatic fire_done();
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        tick(); tick();
        checks++;
        if ({tx_valid, block_valid, busy, err_overrun, err_timeout} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00000", {tx_valid, block_valid, busy, err_overrun, err_timeout});
        end
        reset = 1'b0;
        tick();
        checks++;
        if (block_data !== 128'h0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release buf=%h busy=%b exp buf=0 busy=0", block_data, busy);
        end
    endtask

    task automatic test_stream_aa();
        logic [127:0] exp_blk;
        exp_blk = {16{8'hAA}};
        tx_ready = 1'b1;
        fire_done();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL done_in_idle busy=%b exp=0", busy);
        end
        load_block(0);
        checks++;
        if (busy !== 1'b1 || tx_valid !== 1'b0 || block_valid !== 1'b0 || block_data !== exp_blk) begin
            failures++;
            $display("FAIL collect_aa busy=%b txv=%b bv=%b buf=%h exp busy=1 txv=0 bv=0 buf=%h",
                     busy, tx_valid, block_valid, block_data, exp_blk);
        end
        fire_done();
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (tx_valid !== 1'b1 || block_valid !== 1'b1 || tx_data !== 8'hAA) begin
                failures++;
                $display("FAIL aa_byte%0d txv=%b bv=%b data=%h exp txv=1 bv=1 data=aa", k, tx_valid, block_valid, tx_data);
            end
            tick();
        end
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || block_valid !== 1'b0 || block_data !== 128'h0) begin
            failures++;
            $display("FAIL aa_end txv=%b busy=%b bv=%b buf=%h exp 0 0 0 0", tx_valid, busy, block_valid, block_data);
        end
    endtask

    task automatic test_dual_port();
        logic [127:0] exp_blk;
        ct_ce0 = 1'b1; ct_we0 = 1'b1; ct_addr0 = 7'd5; ct_d0 = 1'b0;
        ct_ce1 = 1'b1; ct_we1 = 1'b1; ct_addr1 = 7'd5; ct_d1 = 1'b1;
        tick();
        checks++;
        if (block_data[5] !== 1'b1) begin
            failures++;
            $display("FAIL same_addr_p1_wins bit5=%b exp=1", block_data[5]);
        end
        ct_addr0 = 7'd9;  ct_d0 = 1'b1;
        ct_addr1 = 7'd20; ct_d1 = 1'b1;
        tick();
        exp_blk = '0;
        exp_blk[5] = 1'b1; exp_blk[9] = 1'b1; exp_blk[20] = 1'b1;
        checks++;
        if (block_data !== exp_blk) begin
            failures++;
            $display("FAIL diff_addr_both buf=%h exp=%h", block_data, exp_blk);
        end
        ct_addr0 = 7'd5; ct_d0 = 1'b1;
        ct_addr1 = 7'd5; ct_d1 = 1'b0;
        tick();
        idle_inputs();
        checks++;
        if (block_data[5] !== 1'b0) begin
            failures++;
            $display("FAIL same_addr_p1_zero bit5=%b exp=0", block_data[5]);
        end
        pulse_reset();
        checks++;
        if (busy !== 1'b0 || block_data !== 128'h0) begin
            failures++;
            $display("FAIL collect_abort busy=%b buf=%h exp busy=0 buf=0", busy, block_data);
        end
    endtask

    task automatic test_backpressure();
        tx_ready = 1'b1;
        load_block(1);
        fire_done();
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== 8'(k)) begin
                failures++;
                $display("FAIL bp_byte%0d txv=%b data=%h exp txv=1 data=%h", k, tx_valid, tx_data, 8'(k));
            end
            if (k == 3) begin
                tx_ready = 1'b0;
                for (int s = 0; s < 10; s++) begin
                    tick();
                    checks++;
                    if (tx_valid !== 1'b1 || tx_data !== 8'h03) begin
                        failures++;
                        $display("FAIL bp_hold%0d txv=%b data=%h exp txv=1 data=03", s, tx_valid, tx_data);
                    end
                end
                tx_ready = 1'b1;
            end
            tick();
        end
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_end txv=%b busy=%b exp 0 0", tx_valid, busy);
        end
    endtask

    task automatic test_overrun();
        tx_ready = 1'b1;
        load_block(1);
        fire_done();
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== 8'(k)) begin
                failures++;
                $display("FAIL ov_byte%0d txv=%b data=%h exp txv=1 data=%h", k, tx_valid, tx_data, 8'(k));
            end
            if (k == 2) begin
                ct_ce0 = 1'b1; ct_we0 = 1'b1; ct_addr0 = 7'd17; ct_d0 = 1'b1;
                ct_ce1 = 1'b1; ct_we1 = 1'b1; ct_addr1 = 7'd16; ct_d1 = 1'b1;
            end
            tick();
            if (k == 2) begin
                idle_inputs();
                checks++;
                if (err_overrun !== 1'b1 || block_data[23:16] !== 8'h02) begin
                    failures++;
                    $display("FAIL ov_flag err=%b byte2=%h exp err=1 byte2=02", err_overrun, block_data[23:16]);
                end
            end
        end
        repeat (5) tick();
        checks++;
        if (err_overrun !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ov_sticky err=%b busy=%b exp err=1 busy=0", err_overrun, busy);
        end
    endtask

    task automatic test_reset_mid_send();
        int seen;
        tx_ready = 1'b1;
        load_block(1);
        fire_done();
        for (int k = 0; k < 7; k++) tick();
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h07) begin
            failures++;
            $display("FAIL rs_at7 txv=%b data=%h exp txv=1 data=07", tx_valid, tx_data);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({tx_valid, busy, block_valid, err_overrun} !== 4'b0 || block_data !== 128'h0) begin
            failures++;
            $display("FAIL rs_async txv=%b busy=%b bv=%b err=%b buf=%h exp all 0",
                     tx_valid, busy, block_valid, err_overrun, block_data);
        end
        tick(); tick();
        reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (tx_valid === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL rs_no_resume active_cycles=%0d exp=0", seen);
        end
    endtask

    task automatic test_watchdog();
        int seen;
        tx_ready = 1'b1;
        seen = 0;
        ct_ce0 = 1'b1; ct_we0 = 1'b1; ct_addr0 = 7'd0; ct_d0 = 1'b1;
        tick();
        idle_inputs();
`ifdef CIPHER_COLLECT_WATCHDOG_EN
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (tx_valid === 1'b1) seen++;
        end
        checks++;
        if (err_timeout !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL wd_early err=%b busy=%b exp err=0 busy=1", err_timeout, busy);
        end
        tick();
        checks++;
        if (err_timeout !== 1'b1 || busy !== 1'b0 || block_data !== 128'h0 || seen !== 0 || tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL wd_fire err=%b busy=%b buf=%h txv_cycles=%0d exp err=1 busy=0 buf=0 txv_cycles=0",
                     err_timeout, busy, block_data, seen);
        end
`else
        for (int c = 0; c < 40; c++) begin
            tick();
            if (tx_valid === 1'b1) seen++;
        end
        checks++;
        if (err_timeout !== 1'b0 || busy !== 1'b1 || seen !== 0) begin
            failures++;
            $display("FAIL wd_off err=%b busy=%b txv_cycles=%0d exp err=0 busy=1 txv_cycles=0", err_timeout, busy, seen);
        end
        fire_done();
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h01) begin
            failures++;
            $display("FAIL wd_off_send txv=%b data=%h exp txv=1 data=01", tx_valid, tx_data);
        end
        repeat (16) tick();
        checks++;
        if (busy !== 1'b0 || tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL wd_off_end busy=%b txv=%b exp 0 0", busy, tx_valid);
        end
`endif
    endtask

    initial begin
        reset    = 1'b1;
        tx_ready = 1'b1;
        idle_inputs();
        test_reset();
        test_stream_aa();
        test_dual_port();
        test_backpressure();
        test_overrun();
        test_reset_mid_send();
        test_watchdog();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
